// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Shared types and the per-bit operator used by logic_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    // Operation select, bitwise over the operand width.
    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_NOT_B = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ELEMENTWISE = 1'b0,
        ACCUMULATE  = 1'b1
    } mode_e;

    // Packet framing state for accumulate mode.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } fsm_e;

    // Result buffer depth; in_ready drops once this many results are held.
    localparam logic [1:0] c_OBUF_DEPTH = 2'd2;

    // Single-bit operator; callers replicate it across the vector width so
    // the function stays independent of WIDTH.
    function automatic logic apply_op(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_NOT_A: r = ~a;
            OP_NOT_B: r = ~b;
            default:  r = a & b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_obuf.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_obuf
//  Description : 2-entry valid/ready FIFO holding results plus their flags.
//                Owns the occupancy count and a registered push-side ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_obuf
    import logic_unit_pkg::*;
#(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push_valid,
    output logic              o_push_ready,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_pop_valid,
    input  logic              i_pop_ready,
    output logic [DATA_W-1:0] o_pop_data
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_count;
    logic              r_ready;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count_nxt;

    assign w_push = i_push_valid && r_ready;
    assign w_pop  = (r_count != 2'd0) && i_pop_ready;

    // Next occupancy; a push and pop in the same cycle cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Storage as head/tail registers: the head is always the visible entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < c_OBUF_DEPTH);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_push_data;
                    end else begin
                        r_tail <= i_push_data;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                end
                2'b11: begin
                    // Push is only possible below full, so count is 1 here:
                    // the new entry replaces the departing head directly.
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_push_ready = r_ready;
    assign o_pop_valid  = (r_count != 2'd0);
    assign o_pop_data   = r_head;

endmodule
`default_nettype wire

// File: rtl/logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit
//  Description : Registered bitwise logic unit with elementwise and
//                accumulate (fold) modes, reduction flags and a 2-entry
//                result buffer on valid/ready streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_mode,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_red_and,
    output logic             out_red_or,
    output logic             out_red_xor,
    output logic             err
);

    fsm_e             r_state;
    logic [WIDTH-1:0] r_acc;
    op_e              r_op;
    logic             r_err;

    op_e              w_in_op;
    mode_e            w_in_mode;
    logic             w_fire;
    logic             w_acc_beat;
    logic             w_start;
    logic             w_frame_err;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;
    logic [WIDTH-1:0] w_elem_res;
    logic [WIDTH-1:0] w_acc_res;
    logic [WIDTH+2:0] w_obuf_in;
    logic [WIDTH+2:0] w_obuf_out;

    assign w_in_op   = op_e'(in_op);
    assign w_in_mode = mode_e'(in_mode);
    assign w_fire    = in_valid && in_ready;

    // Elementwise result uses the live op; the fold uses the packet's op.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        assign w_elem_res[i] = apply_op(w_in_op, in_a[i], in_b[i]);
        assign w_acc_res[i]  = apply_op(r_op, r_acc[i], in_a[i]);
    end

    // Beat classification: what to push and whether this beat opens a packet.
    always_comb begin
        w_acc_beat  = 1'b0;
        w_start     = 1'b0;
        w_frame_err = 1'b0;
        w_push      = 1'b0;
        w_push_data = w_elem_res;
        if (w_fire) begin
            if (r_state == IDLE) begin
                if (w_in_mode == ELEMENTWISE) begin
                    w_push      = 1'b1;
                    w_push_data = w_elem_res;
                end else begin
                    // Missing in_first is flagged but the beat still opens.
                    w_acc_beat  = 1'b1;
                    w_start     = 1'b1;
                    w_frame_err = !in_first;
                    w_push      = in_last;
                    w_push_data = in_a;
                end
            end else begin
                // Inside a packet every beat folds; in_first restarts it.
                w_acc_beat = 1'b1;
                w_push     = in_last;
                if (in_first) begin
                    w_start     = 1'b1;
                    w_frame_err = 1'b1;
                    w_push_data = in_a;
                end else begin
                    w_push_data = w_acc_res;
                end
            end
        end
    end

    // Packet state, accumulator, latched op and sticky framing error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_op    <= OP_AND;
            r_err   <= 1'b0;
        end else begin
            if (w_acc_beat) begin
                if (w_start) begin
                    r_acc <= in_a;
                    r_op  <= w_in_op;
                end else begin
                    r_acc <= w_acc_res;
                end
                r_state <= in_last ? IDLE : ACC;
            end
            if (w_frame_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Flags are captured with the data so they stay aligned through the FIFO.
    assign w_obuf_in = {^w_push_data, |w_push_data, &w_push_data, w_push_data};

    logic_unit_obuf #(
        .DATA_W (WIDTH + 3)
    ) u_obuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (w_push),
        .o_push_ready (in_ready),
        .i_push_data  (w_obuf_in),
        .o_pop_valid  (out_valid),
        .i_pop_ready  (out_ready),
        .o_pop_data   (w_obuf_out)
    );

    assign out_data    = w_obuf_out[WIDTH-1:0];
    assign out_red_and = w_obuf_out[WIDTH];
    assign out_red_or  = w_obuf_out[WIDTH+1];
    assign out_red_xor = w_obuf_out[WIDTH+2];
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit
//  Description : Self-checking bench for logic_unit: directed scenarios then
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_mode;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_red_and;
    logic         out_red_or;
    logic         out_red_xor;
    logic         err;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending results, packet status, sticky error.
    logic [W-1:0] mq[$];
    bit           m_inpkt;
    logic [W-1:0] m_acc;
    logic [2:0]   m_op;
    bit           m_err;

    logic [W-1:0] tp1_tbl [8];

    always #5 clk = ~clk;

    logic_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_mode     (in_mode),
        .in_first    (in_first),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_red_and (out_red_and),
        .out_red_or  (out_red_or),
        .out_red_xor (out_red_xor),
        .err         (err)
    );

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return ~b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic mode, input logic first,
                         input logic last, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_mode   = mode;
        in_first  = first;
        in_last   = last;
        out_ready = ordy;
    endtask

    // One accepted beat applied to the model, straight from the packet rules.
    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2:0] op, input logic mode,
                              input logic first, input logic last);
        if (!m_inpkt && !mode) begin
            mq.push_back(ref_op(op, a, b));
        end else begin
            if (m_inpkt == first) m_err = 1'b1;
            if (!m_inpkt || first) begin
                m_acc = a;
                m_op  = op;
            end else begin
                m_acc = ref_op(m_op, m_acc, a);
            end
            if (last) begin
                mq.push_back(m_acc);
                m_inpkt = 1'b0;
            end else begin
                m_inpkt = 1'b1;
            end
        end
    endtask

    // Advance one clock, update the model, then compare all visible outputs.
    task automatic tick(output bit accepted);
        bit           beat;
        bit           pop;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         mode;
        logic         first;
        logic         last;
        beat  = in_valid && (mq.size() < 2);
        pop   = out_ready && (mq.size() > 0);
        a     = in_a;
        b     = in_b;
        op    = in_op;
        mode  = in_mode;
        first = in_first;
        last  = in_last;
        @(posedge clk);
        #1;
        accepted = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_inpkt = 1'b0;
            m_err   = 1'b0;
            m_acc   = '0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (beat) begin
                model_beat(a, b, op, mode, first, last);
                accepted = 1'b1;
            end
        end
        chk("in_ready", in_ready, (mq.size() < 2));
        chk("out_valid", out_valid, (mq.size() != 0));
        chk("err", err, m_err);
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0]);
            chk("red_and", out_red_and, &mq[0]);
            chk("red_or", out_red_or, |mq[0]);
            chk("red_xor", out_red_xor, ^mq[0]);
        end
    endtask

    initial begin
        bit acc;
        int sent;
        logic [W-1:0] tp4_a [3];

        tp1_tbl = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hC3};
        tp4_a   = '{8'h11, 8'h22, 8'h44};
        m_inpkt = 1'b0;
        m_err   = 1'b0;
        m_acc   = '0;
        m_op    = 3'd0;

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(acc);
        tick(acc);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_red_and, out_red_or, out_red_xor}, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick(acc);

        // Elementwise, all ops back-to-back, one result per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'hF0, 8'h3C, 3'(i), 0, 0, 0, 1);
            tick(acc);
            chk("tp1_accept", acc, 1);
            chk("tp1_valid", out_valid, 1);
            chk("tp1_data", out_data, tp1_tbl[i]);
            if (i == 0) chk("tp1_xor30", out_red_xor, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(acc);
        chk("tp1_drained", out_valid, 0);

        // Accumulate XOR over three beats
        drive(1, 8'h01, 8'hFF, 3'd2, 1, 1, 0, 1);
        tick(acc);
        chk("tp2_no_out1", out_valid, 0);
        drive(1, 8'h02, 8'hFF, 3'd0, 0, 0, 0, 1);
        tick(acc);
        chk("tp2_no_out2", out_valid, 0);
        drive(1, 8'h04, 8'hFF, 3'd0, 1, 0, 1, 1);
        tick(acc);
        chk("tp2_data", out_data, 8'h07);
        chk("tp2_flags", {out_red_and, out_red_or, out_red_xor}, 3'b011);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(acc);

        // Single-beat packet
        drive(1, 8'h5A, 8'h00, 3'd0, 1, 1, 1, 1);
        tick(acc);
        chk("tp3_data", out_data, 8'h5A);
        chk("tp3_err", err, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(acc);

        // Backpressure: two fit, third waits until drain
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1, tp4_a[sent], 8'h0F, 3'd1, 0, 0, 0, 0);
            tick(acc);
            if (acc) sent++;
        end
        chk("tp4_sent", sent, 2);
        chk("tp4_full", in_ready, 0);
        for (int c = 0; c < 10 && sent < 3; c++) begin
            drive(1, tp4_a[sent], 8'h0F, 3'd1, 0, 0, 0, 1);
            tick(acc);
            if (acc) sent++;
        end
        chk("tp4_third", sent, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) tick(acc);
        chk("tp4_empty", out_valid, 0);

        // Framing error: restart mid-packet
        drive(1, 8'h0F, 8'h00, 3'd1, 1, 1, 0, 1);
        tick(acc);
        drive(1, 8'hF0, 8'h00, 3'd1, 1, 1, 0, 1);
        tick(acc);
        chk("tp5_err", err, 1);
        drive(1, 8'h01, 8'h00, 3'd1, 1, 0, 1, 1);
        tick(acc);
        chk("tp5_data", out_data, 8'hF1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(acc);
        chk("tp5_sticky", err, 1);

        // Reset mid-packet with one buffered result
        drive(1, 8'h33, 8'h0F, 3'd0, 0, 0, 0, 0);
        tick(acc);
        drive(1, 8'h0A, 8'h00, 3'd1, 1, 1, 0, 0);
        tick(acc);
        chk("tp6_buffered", out_valid, 1);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(acc);
        chk("tp6_valid", out_valid, 0);
        chk("tp6_ready", in_ready, 1);
        chk("tp6_err", err, 0);
        rst_n = 1'b1;
        drive(1, 8'hAA, 8'h00, 3'd1, 1, 1, 0, 1);
        tick(acc);
        drive(1, 8'h55, 8'h00, 3'd1, 1, 0, 1, 1);
        tick(acc);
        chk("tp6_data", out_data, 8'hFF);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(acc);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 9) < 7), W'($urandom), W'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0));
            tick(acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit.md
Name: logic_unit

Overview:
Parametrised, registered bitwise logic unit for vector operands. It supports runtime op select, an accumulate (fold) mode across multi-beat packets, and reduction flags on each result. Valid/ready streams sit on both sides, with a 2-entry output buffer. It is the standard bitwise-logic stage between stream producers and consumers in our fabric designs.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept beat
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  3  op select (op_e)
in_mode  in  1  0 = elementwise, 1 = accumulate
in_first  in  1  first beat of accumulate packet
in_last  in  1  last beat of accumulate packet
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  result
out_red_and  out  1  &out_data
out_red_or  out  1  |out_data
out_red_xor  out  1  ^out_data (parity)
err  out  1  sticky framing error

Behaviour:
- Reset: synchronous, active-low. It applies on any clk edge with rst_n=0 and overrides all other activity.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, all red_* flags=0, err=0.
  - Internal state after reset: FSM=IDLE, accumulator=0, buffer empty.
- Handshakes:
  - A beat transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - out_data, the red_* flags and out_valid stay stable until the result transfers.
- op_e encodings:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A, 7 NOT_B.
  - Each op is bitwise over WIDTH bits.
  - NOT_A/NOT_B invert the selected operand only.
- Elementwise mode (in_mode=0):
  - Each accepted beat pushes op(in_a, in_b) into the output buffer.
  - in_first/in_last are ignored.
  - Latency: accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1) if the buffer was empty.
- Accumulate mode: FSM states IDLE and ACC.
  - IDLE, beat with mode=1: acc <= in_a. The beat's op and mode are latched for the whole packet. If in_last is also set, push in_a and stay IDLE; otherwise go to ACC.
  - ACC, beat: acc <= op_latched(acc, in_a). in_b, in_op and in_mode are ignored. If in_last, push the new acc and go to IDLE.
  - Non-last beats push nothing.
- Framing errors (err stays set until reset):
  - IDLE, mode=1 beat without in_first: set err and treat the beat as first.
  - ACC, beat with in_first: set err, discard the partial acc, restart with this beat as first.
  - Mode-0 beats received while in ACC are processed as ACC beats; mode is latched.
- Output buffer:
  - 2-entry FIFO, first in, first out.
  - in_ready = (count < 2), driven from a register.
  - A simultaneous push and pop while count=2 is not possible, since in_ready=0. At count=1, a simultaneous push and pop keeps count=1.
  - Full throughput of 1 result/cycle when out_ready is held high.
- red_* flags are computed at push time and stored alongside the data.
- A reset mid-packet drops the partial accumulation and the buffer contents. No result is emitted.

Decomposition:
- logic_unit_pkg contains:
  - op_e (3-bit enum, encodings above)
  - mode_e (ELEMENTWISE=0, ACCUMULATE=1)
  - fsm_e (IDLE, ACC)
  - function apply_op(op_e, a, b) used by both modes
- Sub-module logic_unit_obuf: 2-entry valid/ready FIFO, parametrised on data width (WIDTH+3). It owns count and in_ready generation.

Test Plan:
- WIDTH=8, mode 0, A=F0, B=3C, ops 0..7 back-to-back with out_ready=1 -> results 30, FC, CC, CF, 03, 33, 0F, C3, one per cycle, each 1 cycle after acceptance; red_xor on 30 = 0.
- Mode 1, op XOR, beats A=01(first), 02, 04(last) -> single result 07; red_and=0, red_or=1, red_xor=1; no output on the first two beats.
- Mode 1, single beat first&last, A=5A, op AND -> result 5A, err stays 0.
- out_ready=0, 3 mode-0 beats presented -> 2 accepted, in_ready=0 on the next cycle. Then out_ready=1 -> results drain in order, in_ready returns to 1, third beat accepted.
- Mode 1, beats A=0F(first), F0 with in_first=1 (op OR latched) -> err=1, then A=01(last) -> result F1; err stays 1 until rst_n=0.
- rst_n=0 for 1 cycle while in ACC with 1 result buffered -> out_valid=0, in_ready=1, err=0. Next packet A=AA(first), 55(last), op OR -> FF.
